// File: rtl/plp_io_pkg.sv
// plp_io_pkg: register map and reset constants shared by the LED PWM controller.
//   reg_sel_e   : register select decoded from daddr[3:2]
//   RST_*       : register reset values (truncated to field width by the user)
package plp_io_pkg;
    typedef enum logic [1:0] {
        LEDS_OUT  = 2'd0,
        BLINK_EN  = 2'd1,
        DUTY      = 2'd2,
        BLINK_PER = 2'd3
    } reg_sel_e;
    localparam logic [31:0] RST_LEDS_OUT  = 32'hFFFF_FFFF;
    localparam logic [31:0] RST_BLINK_EN  = 32'h0000_0000;
    localparam logic [31:0] RST_DUTY      = 32'hFFFF_FFFF;
    localparam logic [31:0] RST_BLINK_PER = 32'h0000_0000;
    localparam logic        RST_PHASE     = 1'b1;
endpackage

// File: rtl/led_pwm_timer.sv
// led_pwm_timer: prescaler, PWM frame counter and blink phase generator.
//   clk, rst   : negedge clock, asynchronous active-low reset
//   duty       : programmed duty, sampled only at frame wrap
//   blink_per  : blink half-period in frames, 0 = no blinking
//   per_wr     : blink_per is being written this edge, restarts the blink
//   pwm_on     : PWM output for the current step
//   phase      : blink phase, 1 = lit half
module led_pwm_timer
    import plp_io_pkg::*;
#(
    parameter int PRESCALE = 16,
    parameter int PWM_W    = 8,
    parameter int BLINK_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PWM_W-1:0]   duty,
    input  logic [BLINK_W-1:0] blink_per,
    input  logic               per_wr,
    output logic               pwm_on,
    output logic               phase
);
    localparam int PS_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [PS_W-1:0]    presc_q, presc_d;
    logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d, duty_act_q, duty_act_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d, step, frame, hold, wrap;
    always_comb begin
        step        = presc_q == PS_W'(PRESCALE - 1);
        frame       = step && (pwm_cnt_q == '1);
        presc_d     = step ? '0 : presc_q + 1'b1;
        pwm_cnt_d   = step ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        // duty only lands at frame wrap so a frame never mixes two duties
        duty_act_d  = frame ? duty : duty_act_q;
        hold        = per_wr || (blink_per == '0);
        wrap        = blink_cnt_q == blink_per - 1'b1;
        blink_cnt_d = hold ? '0 : frame ? (wrap ? '0 : blink_cnt_q + 1'b1) : blink_cnt_q;
        phase_d     = hold ? 1'b1 : (frame && wrap) ? ~phase_q : phase_q;
        pwm_on      = (pwm_cnt_q < duty_act_q) || (duty_act_q == '1);
        phase       = phase_q;
    end
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            presc_q     <= '0;
            pwm_cnt_q   <= '0;
            duty_act_q  <= PWM_W'(RST_DUTY);
            blink_cnt_q <= '0;
            phase_q     <= RST_PHASE;
        end else begin
            presc_q     <= presc_d;
            pwm_cnt_q   <= pwm_cnt_d;
            duty_act_q  <= duty_act_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
endmodule

// File: rtl/mod_leds_pwm.sv
// mod_leds_pwm: memory-mapped LED controller with enable, global PWM brightness and per-LED blink.
//   clk, rst     : negedge clock, asynchronous active-low reset
//   ie, iaddr    : instruction port select/address, iout reads 0 when selected
//   de, daddr    : data port select/address, daddr[3:2] picks the register
//   drw, din     : write strobe and write data on the data port
//   iout, dout   : tri-stated bus read data
//   leds         : registered LED drive, 1 = lit
module mod_leds_pwm
    import plp_io_pkg::*;
#(
    parameter int N_LEDS   = 8,
    parameter int PWM_W    = 8,
    parameter int PRESCALE = 16,
    parameter int BLINK_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ie,
    input  logic              de,
    input  logic [31:0]       iaddr,
    input  logic [31:0]       daddr,
    input  logic              drw,
    input  logic [31:0]       din,
    output logic [31:0]       iout,
    output logic [31:0]       dout,
    output logic [N_LEDS-1:0] leds
);
    logic [N_LEDS-1:0]  led_out_q, led_out_d, blink_en_q, blink_en_d, leds_q, leds_d;
    logic [PWM_W-1:0]   duty_q, duty_d;
    logic [BLINK_W-1:0] blink_per_q, blink_per_d;
    logic [31:0]        rdata;
    logic               wr, per_wr, pwm_on, phase, unused_ok;
    reg_sel_e           sel;
    assign unused_ok = ^{iaddr, daddr, din};
    led_pwm_timer #(.PRESCALE(PRESCALE), .PWM_W(PWM_W), .BLINK_W(BLINK_W)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .duty      (duty_q),
        .blink_per (blink_per_q),
        .per_wr    (per_wr),
        .pwm_on    (pwm_on),
        .phase     (phase)
    );
    always_comb begin
        sel         = reg_sel_e'(daddr[3:2]);
        wr          = de && drw;
        per_wr      = wr && (sel == BLINK_PER);
        led_out_d   = (wr && sel == LEDS_OUT) ? din[N_LEDS-1:0] : led_out_q;
        blink_en_d  = (wr && sel == BLINK_EN) ? din[N_LEDS-1:0] : blink_en_q;
        duty_d      = (wr && sel == DUTY) ? din[PWM_W-1:0] : duty_q;
        blink_per_d = per_wr ? din[BLINK_W-1:0] : blink_per_q;
        rdata       = sel == LEDS_OUT ? 32'(led_out_q) :
                      sel == BLINK_EN ? 32'(blink_en_q) :
                      sel == DUTY     ? 32'(duty_q) : 32'(blink_per_q);
        // blinking LEDs go dark in the off phase, the rest ignore phase
        leds_d      = led_out_q & {N_LEDS{pwm_on}} & (~blink_en_q | {N_LEDS{phase}});
    end
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            led_out_q   <= N_LEDS'(RST_LEDS_OUT);
            blink_en_q  <= N_LEDS'(RST_BLINK_EN);
            duty_q      <= PWM_W'(RST_DUTY);
            blink_per_q <= BLINK_W'(RST_BLINK_PER);
            leds_q      <= '1;
        end else begin
            led_out_q   <= led_out_d;
            blink_en_q  <= blink_en_d;
            duty_q      <= duty_d;
            blink_per_q <= blink_per_d;
            leds_q      <= leds_d;
        end
    end
    assign iout = ie ? 32'h0 : 32'hz;
    assign dout = de ? rdata : 32'hz;
    assign leds = leds_q;
endmodule
